// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing source with four selectable test patterns.
// Stage 0 holds the FSM, the h/v counters, the latched mode and the colour-bar
// sub-counter; every output is registered from stage 0 (one cycle of latency).
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BLANK  = 45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  output logic       o_hav,
  output logic       o_vav,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_frame_start,
  output logic       o_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_LEN = H_ACTIVE / 8;
  localparam int unsigned BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  // stage 0
  state_e        state_q,   state_d;
  logic [HW-1:0] h_cnt_q,   h_cnt_d;
  logic [VW-1:0] v_cnt_q,   v_cnt_d;
  logic [1:0]    mode_q,    mode_d;
  logic [BW-1:0] bar_sub_q, bar_sub_d;
  logic [2:0]    bar_k_q,   bar_k_d;

  // registered outputs
  logic       hav_q,  hav_d;
  logic       vav_q,  vav_d;
  logic [7:0] r_q,    r_d;
  logic [7:0] g_q,    g_d;
  logic [7:0] b_q,    b_d;
  logic       fs_q,   fs_d;
  logic       busy_q, busy_d;

  logic       frame_last;
  logic       running;
  logic [7:0] h8;
  logic [7:0] v8;
  logic [7:0] chk;

  // Next state, counter advance, bar sub-counter and mode latch.
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    mode_d    = mode_q;
    bar_sub_d = bar_sub_q;
    bar_k_d   = bar_k_q;

    frame_last = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    if (state_q != S_IDLE) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      // Bars restart from index 0 once the active part of the line is done,
      // so the sub-counter is already aligned when the next line begins.
      if (h_cnt_q >= H_ACT_LAST) begin
        bar_sub_d = '0;
        bar_k_d   = '0;
      end else if (bar_sub_q == BAR_LAST) begin
        bar_sub_d = '0;
        bar_k_d   = bar_k_q + 3'd1;
      end else begin
        bar_sub_d = bar_sub_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d   = S_RUN;
          h_cnt_d   = '0;
          v_cnt_d   = '0;
          bar_sub_d = '0;
          bar_k_d   = '0;
          mode_d    = i_mode;
        end
      end
      S_RUN: begin
        if (!i_en) begin
          state_d = frame_last ? S_IDLE : S_DRAIN;
        end else if (frame_last) begin
          mode_d = i_mode;
        end
      end
      S_DRAIN: begin
        if (frame_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from stage 0: timing flags and pattern pixel data.
  always_comb begin
    running = (state_q != S_IDLE);
    hav_d   = running && (h_cnt_q < H_ACT);
    vav_d   = running && (v_cnt_q < V_ACT);
    fs_d    = running && (h_cnt_q == '0) && (v_cnt_q == '0);
    busy_d  = running;
    h8      = 8'(h_cnt_q);
    v8      = 8'(v_cnt_q);
    chk     = (h8[4] ^ v8[4]) ? 8'hFF : 8'h00;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (hav_d && vav_d) begin
      case (mode_q)
        2'd0: begin
          r_d = bar_k_q[1] ? 8'h00 : 8'hFF;
          g_d = bar_k_q[2] ? 8'h00 : 8'hFF;
          b_d = bar_k_q[0] ? 8'h00 : 8'hFF;
        end
        2'd1: begin
          r_d = h8;
          g_d = h8;
          b_d = h8;
        end
        2'd2: begin
          r_d = v8;
          g_d = v8;
          b_d = v8;
        end
        default: begin
          r_d = chk;
          g_d = chk;
          b_d = chk;
        end
      endcase
    end
  end

  // Stage-0 and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      mode_q    <= '0;
      bar_sub_q <= '0;
      bar_k_q   <= '0;
      hav_q     <= 1'b0;
      vav_q     <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mode_q    <= mode_d;
      bar_sub_q <= bar_sub_d;
      bar_k_q   <= bar_k_d;
      hav_q     <= hav_d;
      vav_q     <= vav_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
    end
  end

  assign o_hav         = hav_q;
  assign o_vav         = vav_q;
  assign o_r           = r_q;
  assign o_g           = g_q;
  assign o_b           = b_q;
  assign o_frame_start = fs_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: small raster (16+4 x 4+2, 120 cycles/frame)
// plus a 64x32 instance for the checkerboard toggle.
module tb_video_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, i_en, en2;
  logic [1:0] i_mode, mode2;
  logic       o_hav, o_vav, o_frame_start, o_busy;
  logic [7:0] o_r, o_g, o_b;
  logic       hav2, vav2, fs2, busy2;
  logic [7:0] r2, g2, b2;

  video_pattern_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(4), .V_BLANK(2)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode),
    .o_hav(o_hav), .o_vav(o_vav), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_frame_start(o_frame_start), .o_busy(o_busy)
  );

  video_pattern_gen #(.H_ACTIVE(64), .H_BLANK(4), .V_ACTIVE(32), .V_BLANK(2)) dut2 (
    .clk(clk), .rst(rst), .i_en(en2), .i_mode(mode2),
    .o_hav(hav2), .o_vav(vav2), .o_r(r2), .o_g(g2), .o_b(b2),
    .o_frame_start(fs2), .o_busy(busy2)
  );

  int tests = 0;
  int fails = 0;

  logic        c_hav  [0:399];
  logic        c_vav  [0:399];
  logic        c_fs   [0:399];
  logic        c_busy [0:399];
  logic [23:0] c_rgb  [0:399];
  logic [23:0] c2_rgb [0:2399];

  typedef struct {
    logic [1:0]  mode;
    int          h;
    int          v;
    logic        hav;
    logic        vav;
    logic [23:0] rgb;
  } vec_t;

  vec_t        vecs [0:39];
  int          nv = 0;
  logic [23:0] bars [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input int h, input int v,
                     input logic hv, input logic vv, input logic [23:0] rgb);
    vecs[nv].mode = m;
    vecs[nv].h    = h;
    vecs[nv].v    = v;
    vecs[nv].hav  = hv;
    vecs[nv].vav  = vv;
    vecs[nv].rgb  = rgb;
    nv++;
  endtask

  task automatic sample(input int idx);
    @(negedge clk);
    c_hav[idx]  = o_hav;
    c_vav[idx]  = o_vav;
    c_fs[idx]   = o_frame_start;
    c_busy[idx] = o_busy;
    c_rgb[idx]  = {o_r, o_g, o_b};
  endtask

  // i_en sampled at edge N; returns at the negedge after N (outputs still idle).
  task automatic start(input logic [1:0] m);
    @(posedge clk); #1;
    i_mode = m;
    i_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_at_edge_n", 32'(o_busy), 32'd0);
  endtask

  task automatic one_frame(input logic [1:0] m);
    start(m);
    i_en = 1'b0;
    for (int c = 0; c <= 120; c++) sample(c);
  endtask

  function automatic int count_act(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (c_hav[i] && c_vav[i]) n++;
    return n;
  endfunction

  function automatic int count_fs(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (c_fs[i]) n++;
    return n;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    add(0, 0, 0, 1, 1, 24'hFFFFFF);  add(0, 1, 0, 1, 1, 24'hFFFFFF);
    add(0, 2, 0, 1, 1, 24'hFFFF00);  add(0, 4, 1, 1, 1, 24'h00FFFF);
    add(0, 6, 2, 1, 1, 24'h00FF00);  add(0, 8, 3, 1, 1, 24'hFF00FF);
    add(0, 11, 0, 1, 1, 24'hFF0000); add(0, 12, 2, 1, 1, 24'h0000FF);
    add(0, 15, 3, 1, 1, 24'h000000); add(0, 16, 0, 0, 1, 24'h000000);
    add(0, 19, 3, 0, 1, 24'h000000); add(0, 0, 4, 1, 0, 24'h000000);
    add(0, 19, 5, 0, 0, 24'h000000);
    add(1, 0, 0, 1, 1, 24'h000000);  add(1, 5, 1, 1, 1, 24'h050505);
    add(1, 15, 3, 1, 1, 24'h0F0F0F); add(1, 16, 1, 0, 1, 24'h000000);
    add(1, 3, 4, 1, 0, 24'h000000);
    add(2, 0, 0, 1, 1, 24'h000000);  add(2, 7, 1, 1, 1, 24'h010101);
    add(2, 9, 2, 1, 1, 24'h020202);  add(2, 15, 3, 1, 1, 24'h030303);
    add(2, 17, 2, 0, 1, 24'h000000);
    add(3, 0, 0, 1, 1, 24'h000000);  add(3, 10, 2, 1, 1, 24'h000000);
    add(3, 15, 3, 1, 1, 24'h000000);

    // reset state
    rst = 1'b1; i_en = 1'b0; i_mode = 2'd0; en2 = 1'b0; mode2 = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hav", 32'(o_hav), 32'd0);
    chk("rst_vav", 32'(o_vav), 32'd0);
    chk("rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    chk("rst_fs", 32'(o_frame_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // single-cycle enable, one frame per mode, table vectors
    for (int m = 0; m < 4; m++) begin
      one_frame(2'(m));
      for (int i = 0; i < nv; i++) begin
        if (vecs[i].mode == 2'(m)) begin
          idx = vecs[i].v * 20 + vecs[i].h;
          chk($sformatf("m%0d_hav(%0d,%0d)", m, vecs[i].h, vecs[i].v), 32'(c_hav[idx]), 32'(vecs[i].hav));
          chk($sformatf("m%0d_vav(%0d,%0d)", m, vecs[i].h, vecs[i].v), 32'(c_vav[idx]), 32'(vecs[i].vav));
          chk($sformatf("m%0d_rgb(%0d,%0d)", m, vecs[i].h, vecs[i].v), 32'(c_rgb[idx]), 32'(vecs[i].rgb));
        end
      end
      for (int v = 0; v < 4; v++) begin
        for (int h = 0; h < 20; h++) begin
          logic [23:0] e;
          if (h >= 16)     e = 24'h0;
          else if (m == 0) e = bars[h / 2];
          else if (m == 1) e = 24'(h) * 24'h010101;
          else if (m == 2) e = 24'(v) * 24'h010101;
          else             e = 24'h0;
          chk($sformatf("m%0d_line_px(%0d,%0d)", m, h, v), 32'(c_rgb[v * 20 + h]), 32'(e));
        end
      end
      chk($sformatf("m%0d_active_count", m), 32'(count_act(0, 119)), 32'd64);
      chk($sformatf("m%0d_fs_count", m), 32'(count_fs(0, 119)), 32'd1);
      chk($sformatf("m%0d_fs_first", m), 32'(c_fs[0]), 32'd1);
      n = 0;
      for (int i = 0; i < 120; i++) if (c_busy[i]) n++;
      chk($sformatf("m%0d_busy_frame", m), 32'(n), 32'd120);
      chk($sformatf("m%0d_busy_end", m), 32'(c_busy[120]), 32'd0);
      chk($sformatf("m%0d_hav_end", m), 32'(c_hav[120]), 32'd0);
      for (int k = 0; k < 5; k++) sample(200 + k);
      chk($sformatf("m%0d_idle_quiet", m), 32'(count_fs(200, 204) + count_act(200, 204)), 32'd0);
    end

    // back-to-back frames, mid-frame mode change, drain ignoring re-enable
    start(2'd0);
    for (int c = 0; c <= 370; c++) begin
      sample(c);
      if (c == 60)  i_mode = 2'd1;
      if (c == 250) i_en = 1'b0;
      if (c == 270) i_en = 1'b1;
      if (c == 359) i_en = 1'b0;
    end
    chk("b2b_fs_count", 32'(count_fs(0, 370)), 32'd3);
    chk("b2b_fs_120", 32'(c_fs[120]), 32'd1);
    chk("b2b_fs_240", 32'(c_fs[240]), 32'd1);
    chk("b2b_f1_cyan", 32'(c_rgb[64]), 32'h00FFFF);
    chk("b2b_f1_blue", 32'(c_rgb[72]), 32'h0000FF);
    chk("b2b_f2_ramp8", 32'(c_rgb[128]), 32'h080808);
    chk("b2b_f2_ramp5", 32'(c_rgb[165]), 32'h050505);
    chk("b2b_f2_blank", 32'(c_rgb[136]), 32'h000000);
    chk("b2b_f1_active", 32'(count_act(0, 119)), 32'd64);
    chk("drain_active", 32'(count_act(240, 359)), 32'd64);
    chk("drain_ramp", 32'(c_rgb[240 + 20 + 9]), 32'h090909);
    chk("drain_busy_last", 32'(c_busy[359]), 32'd1);
    chk("drain_busy_fall", 32'(c_busy[360]), 32'd0);
    chk("drain_busy_after", 32'(c_busy[370]), 32'd0);
    chk("drain_quiet", 32'(count_act(360, 370) + count_fs(360, 370)), 32'd0);

    // reset during an active pixel, then a clean restart
    start(2'd2);
    for (int c = 0; c <= 44; c++) sample(c);
    chk("pre_rst_active", 32'(c_rgb[44]), 32'h020202);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hav", 32'(o_hav), 32'd0);
    chk("mid_rst_vav", 32'(o_vav), 32'd0);
    chk("mid_rst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_fs", 32'(o_frame_start), 32'd0);
    rst = 1'b0;
    i_en = 1'b0;
    one_frame(2'd1);
    chk("restart_fs", 32'(c_fs[0]), 32'd1);
    chk("restart_px0", 32'(c_rgb[0]), 32'h000000);
    chk("restart_px3", 32'(c_rgb[3]), 32'h030303);
    chk("restart_px15_1", 32'(c_rgb[35]), 32'h0F0F0F);
    chk("restart_active", 32'(count_act(0, 119)), 32'd64);
    chk("restart_busy_end", 32'(c_busy[120]), 32'd0);

    // 64x32 checkerboard: toggles every 16 pixels and every 16 lines
    @(posedge clk); #1;
    en2 = 1'b1;
    @(posedge clk); #1;
    en2 = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2312; c++) begin
      @(negedge clk);
      c2_rgb[c] = {r2, g2, b2};
    end
    chk("ck(0,0)",   32'(c2_rgb[0]),            32'h000000);
    chk("ck(15,0)",  32'(c2_rgb[15]),           32'h000000);
    chk("ck(16,0)",  32'(c2_rgb[16]),           32'hFFFFFF);
    chk("ck(32,0)",  32'(c2_rgb[32]),           32'h000000);
    chk("ck(48,3)",  32'(c2_rgb[3 * 68 + 48]),  32'hFFFFFF);
    chk("ck(0,16)",  32'(c2_rgb[16 * 68]),      32'hFFFFFF);
    chk("ck(16,16)", 32'(c2_rgb[16 * 68 + 16]), 32'h000000);
    chk("ck(47,20)", 32'(c2_rgb[20 * 68 + 47]), 32'hFFFFFF);
    chk("ck(63,31)", 32'(c2_rgb[31 * 68 + 63]), 32'h000000);
    chk("ck(64,0)",  32'(c2_rgb[64]),           32'h000000);
    n = 0;
    for (int h = 1; h < 64; h++) if (c2_rgb[h] != c2_rgb[h - 1]) n++;
    chk("ck_h_toggles", 32'(n), 32'd3);
    n = 0;
    for (int v = 1; v < 32; v++) if (c2_rgb[v * 68] != c2_rgb[(v - 1) * 68]) n++;
    chk("ck_v_toggles", 32'(n), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Video source that produces the `hav`/`vav` active-region timing and 8-bit RGB pixel data consumed by the grayscale conversion pipeline. It is the driving end of that interface. It generates raster timing from programmable active and blanking sizes and fills the active region with one of four test patterns. It lets the downstream pixel path and memory controller be exercised without an external video input.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 8, ≥ 8.
- `H_BLANK`, 160: blanking pixels per line; ≥ 1.
- `V_ACTIVE`, 480: active lines per frame; ≥ 1.
- `V_BLANK`, 45: blanking lines per frame; ≥ 1.

Ports:
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `i_en`  in  1  run request; level-sensitive.
- `i_mode`  in  2  pattern select: 0 colour bars, 1 horizontal ramp, 2 vertical ramp, 3 checkerboard.
- `o_hav`  out  1  horizontal active.
- `o_vav`  out  1  vertical active.
- `o_r`, `o_g`, `o_b`  out  8 each  pixel data; 0 outside the active region.
- `o_frame_start`  out  1  one-cycle pulse coincident with the first active pixel of each frame.
- `o_busy`  out  1  high while the FSM is not IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
  - IDLE → RUN when `i_en`=1. Counters are cleared and the mode is latched.
  - RUN → DRAIN when `i_en`=0 and the last cycle of the frame has not been reached.
  - RUN → IDLE directly when `i_en`=0 in the last cycle of the frame.
  - DRAIN → IDLE at the last cycle of the current frame (`h_cnt`=H_TOTAL-1, `v_cnt`=V_TOTAL-1).
  - DRAIN ignores `i_en`. A frame is never truncated.
- Totals are H_TOTAL = H_ACTIVE+H_BLANK and V_TOTAL = V_ACTIVE+V_BLANK.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on the `h_cnt` wrap and wraps 0..V_TOTAL-1.
- The active region is `h_cnt`<H_ACTIVE && `v_cnt`<V_ACTIVE. `hav` is `h_cnt`<H_ACTIVE, and is asserted during vertical blanking lines as well. `vav` is `v_cnt`<V_ACTIVE.
- At each frame wrap in RUN, the next frame continues immediately with no gap cycle.
- `i_mode` is latched only at IDLE→RUN and at each frame wrap. A mid-frame change takes effect next frame.
- Pattern data is generated when both `hav` and `vav` are set; otherwise R=G=B=0.
- Mode 0, colour bars:
  - Bar index k (3 bits) comes from a sub-counter of width H_ACTIVE/8. No divider.
  - R=FF when k[1]=0, G=FF when k[2]=0, B=FF when k[0]=0, else 00.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 1, horizontal ramp: R=G=B=`h_cnt`[7:0]; wraps every 256 pixels.
- Mode 2, vertical ramp: R=G=B=`v_cnt`[7:0].
- Mode 3, checkerboard: R=G=B = (`h_cnt`[4]^`v_cnt`[4]) ? FF : 00.
- Counter widths are sized with $clog2 of the totals. No overflow is permitted.

## Timing
- Reset behaviour: all outputs are 0 (`o_hav`, `o_vav`, `o_r`, `o_g`, `o_b`, `o_frame_start`, `o_busy`). The FSM is IDLE with counters at 0 and mode at 0.
- `rst` overrides everything, including mid-frame. At the edge after `rst` is sampled high, outputs are 0 and the state is IDLE. No partial frame resumes.
- Counters and state form stage 0. All outputs are registered from stage 0, giving 1 cycle of latency.
  - `i_en` sampled at edge N moves the state to RUN at edge N with counters at (0,0).
  - `o_busy`=1 from edge N+1. `o_hav`=`o_vav`=1 and `o_frame_start`=1 from edge N+1 with the first pixel.
- `o_hav`, `o_vav` and the data are cycle-aligned. The pixel for (`h_cnt`, `v_cnt`) appears exactly 1 cycle after the counters hold that value.
- `o_busy` falls 1 cycle after the last blanking cycle of the final frame. `o_hav`/`o_vav` are already 0 at that point.
- In IDLE, outputs hold 0 and `o_frame_start` is never asserted.

## Test plan
Use small parameters: H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_BLANK=2 (120 cycles per frame).
- Reset, then `i_en`=1 for 1 cycle, then 0 → exactly 1 frame. Count 64 cycles with `o_hav`&`o_vav`=1, exactly one `o_frame_start` pulse, then `o_busy`=0 at the 121st cycle after start.
- `i_en` held at 1, mode 0 → each active line reads FFFFFF×2, FFFF00×2, 00FFFF×2, 00FF00×2, FF00FF×2, FF0000×2, 0000FF×2, 000000×2. Blanking data is 0. Frames repeat back-to-back, with `o_frame_start` every 120 cycles.
- Mode 1 → line pixels 00..0F. Mode 2 → line v is all v. Mode 3 → all 00 (`h_cnt`[4]=`v_cnt`[4]=0 in the active area at these sizes). Separately, mode 3 with H_ACTIVE=64, V_ACTIVE=32 → the value toggles every 16 pixels and every 16 lines.
- Change `i_mode` 0→1 mid-frame → the current frame remains bars and the next frame is the ramp.
- Drop `i_en` mid-frame → the frame completes, DRAIN ignores a re-asserted `i_en`, and IDLE follows.
- Assert `rst` mid-active-pixel → at the next edge all outputs are 0 and `o_busy`=0. A new `i_en` restarts cleanly at (0,0).
